// File: rtl/quad_gen_pkg.sv
// Shared definitions for quadrature_generator: FSM state encodings, the
// output-mode constants and the quadrature Gray-sequence step function.
package quad_gen_pkg;

    // FSM states
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Output modes
    localparam logic MODE_QUAD   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Next {A,B} level in the quadrature cycle.
    // dir=0 (A leads): 00->10->11->01->00; dir=1 (B leads): 00->01->11->10->00.
    function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic dir);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = dir ? 2'b01 : 2'b10;
            2'b10:   nxt = dir ? 2'b00 : 2'b11;
            2'b11:   nxt = dir ? 2'b10 : 2'b01;
            default: nxt = dir ? 2'b11 : 2'b00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quadrature_generator_phase_timer.sv
// Period timer: down-counter that emits a one-cycle tick every `period` clocks
// once started. The first tick falls in the cycle `period` clocks after start,
// so a register updated on tick_c changes exactly `period` edges after start.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load period and begin counting (wins over clear)
//   clear      stop counting
//   period     clocks per tick, expected >= 1
//   tick_c     combinational tick (decoded from registered count)
module phase_timer
    import quad_gen_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick_c
);

    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [PERIOD_WIDTH-1:0] per_q;
    logic                    run_q;
    logic [PERIOD_WIDTH-1:0] load_c;

    // A zero period degenerates to ticking every clock
    assign load_c = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
    assign tick_c = run_q && (cnt_q == '0);

    // Counter with reload on every tick
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            per_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= load_c;
            per_q <= load_c;
            run_q <= 1'b1;
        end else if (clear) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (tick_c) begin
            cnt_q <= per_q;
        end else if (run_q) begin
            cnt_q <= cnt_q - PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/quadrature_generator.sv
// Quadrature / step-direction pulse generator. Accepts a command (steps,
// direction, period) over valid/ready and emits the corresponding CHA/CHB
// edges, tracking a wrapping position count.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mode            0 quadrature, 1 step/dir; sampled at accept
//   cmd_valid/ready command handshake (ready is decoded from state)
//   cmd_steps       step count, cmd_dir direction, cmd_period clocks per phase
//   abort           stop the running command after the current cycle
//   pos_clr         zero the position counter (beats a coincident step)
//   CHA, CHB        output channels
//   busy, done      command running / one-cycle completion pulse
//   pos             generated position
module quadrature_generator
    import quad_gen_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [COUNT_WIDTH-1:0]  cmd_steps,
    input  logic                    cmd_dir,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                    abort,
    input  logic                    pos_clr,
    output logic                    CHA,
    output logic                    CHB,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  pos
);

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic                    dir_q, dir_d;
    logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
    logic [PERIOD_WIDTH-1:0] per_q, per_d;
    logic                    init_q, init_d;
    logic                    ph_q, ph_d;
    logic [1:0]              ab_q, ab_d;
    logic [COUNT_WIDTH-1:0]  pos_q, pos_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [PERIOD_WIDTH-1:0] p_cmd_c;
    logic                    step_c;
    logic                    t_start_c;
    logic                    t_clear_c;
    logic [PERIOD_WIDTH-1:0] t_period_c;
    logic                    tick_c;

    phase_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (t_start_c),
        .clear  (t_clear_c),
        .period (t_period_c),
        .tick_c (tick_c)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign CHA       = ab_q[1];
    assign CHB       = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pos       = pos_q;

    // Next-state, datapath and timer control
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        rem_d      = rem_q;
        per_d      = per_q;
        init_d     = init_q;
        ph_d       = ph_q;
        ab_d       = ab_q;
        done_d     = 1'b0;
        step_c     = 1'b0;
        t_start_c  = 1'b0;
        t_clear_c  = 1'b0;
        t_period_c = per_q;
        p_cmd_c    = (cmd_period == '0) ? PERIOD_WIDTH'(1) : cmd_period;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    dir_d   = cmd_dir;
                    rem_d   = cmd_steps;
                    per_d   = p_cmd_c;
                    ph_d    = 1'b0;
                    // Step/dir spends one cycle setting the direction level first
                    init_d  = (mode == MODE_SINGLE);
                    if (mode == MODE_QUAD) begin
                        t_start_c  = 1'b1;
                        t_period_c = p_cmd_c;
                    end
                end
            end
            ST_RUN: begin
                if (abort || ((rem_q == '0) && !ph_q)) begin
                    // Finish: levels hold, no edge this cycle
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    init_d    = 1'b0;
                    ph_d      = 1'b0;
                    t_clear_c = 1'b1;
                end else if (init_q) begin
                    init_d     = 1'b0;
                    ab_d       = {1'b0, dir_q};
                    t_start_c  = 1'b1;
                    t_period_c = per_q;
                end else if (tick_c) begin
                    if (mode_q == MODE_QUAD) begin
                        ab_d   = next_ab(ab_q, dir_q);
                        rem_d  = rem_q - COUNT_WIDTH'(1);
                        step_c = 1'b1;
                    end else if (!ph_q) begin
                        // Rising edge counts the step
                        ab_d[1] = 1'b1;
                        ph_d    = 1'b1;
                        rem_d   = rem_q - COUNT_WIDTH'(1);
                        step_c  = 1'b1;
                    end else begin
                        ab_d[1] = 1'b0;
                        ph_d    = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pos_clr) begin
            pos_d = '0;
        end else if (step_c) begin
            pos_d = dir_q ? pos_q - COUNT_WIDTH'(1) : pos_q + COUNT_WIDTH'(1);
        end else begin
            pos_d = pos_q;
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_QUAD;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            per_q   <= PERIOD_WIDTH'(1);
            init_q  <= 1'b0;
            ph_q    <= 1'b0;
            ab_q    <= 2'b00;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            init_q  <= init_d;
            ph_q    <= ph_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator: a vector table of whole commands
// plus hand sequences for step/dir timing, abort, pos_clr, back-to-back and reset.
module tb_quadrature_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [15:0] cmd_period;
    logic        abort;
    logic        pos_clr;
    logic        CHA;
    logic        CHB;
    logic        busy;
    logic        done;
    logic [15:0] pos;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    quadrature_generator #(
        .COUNT_WIDTH (16),
        .PERIOD_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .cmd_period(cmd_period),
        .abort     (abort),
        .pos_clr   (pos_clr),
        .CHA       (CHA),
        .CHB       (CHB),
        .busy      (busy),
        .done      (done),
        .pos       (pos)
    );

    typedef struct {
        logic        m;
        logic        d;
        logic [15:0] steps;
        logic [15:0] per;
        logic        clr;
        int          edges;
        int          first;
        int          done_at;
        logic [1:0]  ab;
        logic [15:0] pos;
        logic [15:0] seq;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [15:0] s, input logic [15:0] p);
        mode       = m;
        cmd_dir    = d;
        cmd_steps  = s;
        cmd_period = p;
        cmd_valid  = 1'b1;
        step();
        cmd_valid  = 1'b0;
        // Garbage on the command inputs while running must be ignored
        mode       = ~m;
        cmd_dir    = ~d;
        cmd_steps  = 16'hFFFF;
        cmd_period = 16'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        logic [1:0] exp_ab;
        int  edges;
        int  first;
        int  done_at;
        logic seq_ok;
        logic ok;
        logic exp_a;

        //          m     d     steps   per    clr  edges first done  ab     pos       seq
        vecs[0] = '{1'b0, 1'b0, 16'd8, 16'd4, 1'b0, 8,    4,    33,  2'b00, 16'h0008, 16'hB4B4};
        vecs[1] = '{1'b0, 1'b1, 16'd3, 16'd0, 1'b1, 3,    1,    4,   2'b10, 16'hFFFD, 16'h7800};
        vecs[2] = '{1'b1, 1'b1, 16'd2, 16'd3, 1'b1, 2,    4,    14,  2'b01, 16'hFFFE, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 16'd5, 16'd2, 1'b0, 5,    2,    11,  2'b00, 16'h0003, 16'h2D00};
        vecs[4] = '{1'b0, 1'b0, 16'd0, 16'd7, 1'b0, 0,    0,    1,   2'b00, 16'h0003, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 1,    2,    4,   2'b00, 16'h0004, 16'h0000};

        rst        = 1'b1;
        mode       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_dir    = 1'b0;
        cmd_period = '0;
        abort      = 1'b0;
        pos_clr    = 1'b0;
        step();
        step();
        chk("rst_cha", 32'(CHA), 32'd0);
        chk("rst_chb", 32'(CHB), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        step();

        // Table-driven commands
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) begin
                pos_clr = 1'b1;
                step();
                pos_clr = 1'b0;
            end
            chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'd1);
            issue(vecs[i].m, vecs[i].d, vecs[i].steps, vecs[i].per);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            prev    = {CHA, CHB};
            edges   = 0;
            first   = -1;
            done_at = -1;
            seq_ok  = 1'b1;
            for (int k = 1; k <= 200; k++) begin
                step();
                cur = {CHA, CHB};
                if (!vecs[i].m) begin
                    if (cur != prev) begin
                        if (edges < 8) begin
                            exp_ab = vecs[i].seq[15-2*edges -: 2];
                            if (cur !== exp_ab) seq_ok = 1'b0;
                        end
                        if (first < 0) first = k;
                        edges++;
                    end
                end else if (cur[1] && !prev[1]) begin
                    if (first < 0) first = k;
                    edges++;
                end
                prev = cur;
                if (done) begin
                    done_at = k;
                    break;
                end
            end
            chk($sformatf("v%0d_done_cycle", i), 32'(done_at), 32'(vecs[i].done_at));
            chk($sformatf("v%0d_edges", i), 32'(edges), 32'(vecs[i].edges));
            if (vecs[i].edges > 0)
                chk($sformatf("v%0d_first_edge", i), 32'(first), 32'(vecs[i].first));
            chk($sformatf("v%0d_ab", i), 32'({CHA, CHB}), 32'(vecs[i].ab));
            chk($sformatf("v%0d_pos", i), 32'(pos), 32'(vecs[i].pos));
            if (!vecs[i].m && vecs[i].edges > 0)
                chk($sformatf("v%0d_gray_seq", i), 32'(seq_ok), 32'd1);
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_ready_done", i), 32'(cmd_ready), 32'd1);
        end

        // Step/dir cycle trace: AB=00, pos=4; dir=1, steps=2, P=3
        issue(1'b1, 1'b1, 16'd2, 16'd3);
        ok = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_a = ((k >= 4) && (k <= 6)) || ((k >= 10) && (k <= 12));
            if (CHA !== exp_a || CHB !== 1'b1) ok = 1'b0;
            if (k < 14 && done !== 1'b0) ok = 1'b0;
        end
        chk("single_trace", 32'(ok), 32'd1);
        chk("single_done", 32'(done), 32'd1);
        chk("single_pos", 32'(pos), 32'h0002);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);

        // Abort coinciding with the 4th edge: AB=01 start, dir=0, P=2
        pos_clr = 1'b1;
        step();
        pos_clr = 1'b0;
        issue(1'b0, 1'b0, 16'd10, 16'd2);
        for (int k = 1; k <= 7; k++) step();
        chk("abort_pre_ab", 32'({CHA, CHB}), 32'b11);
        chk("abort_pre_pos", 32'(pos), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_ab_held", 32'({CHA, CHB}), 32'b11);
        chk("abort_pos", 32'(pos), 32'd3);
        chk("abort_busy", 32'(busy), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if ({CHA, CHB} !== 2'b11 || done !== 1'b0) ok = 1'b0;
        end
        chk("abort_quiet", 32'(ok), 32'd1);
        // Abort in IDLE with a simultaneous command: command accepted
        abort = 1'b1;
        issue(1'b0, 1'b0, 16'd1, 16'd1);
        abort = 1'b0;
        chk("abort_idle_ignored", 32'(busy), 32'd1);
        step();
        chk("gray_continue", 32'({CHA, CHB}), 32'b01);
        chk("gray_continue_pos", 32'(pos), 32'd4);
        step();
        chk("gray_continue_done", 32'(done), 32'd1);

        // pos_clr coinciding with an edge; command issued in done cycle
        issue(1'b0, 1'b0, 16'd2, 16'd2);
        step();
        step();
        chk("clr_pre_pos", 32'(pos), 32'd5);
        step();
        pos_clr = 1'b1;
        step();
        pos_clr = 1'b0;
        chk("clr_wins_pos", 32'(pos), 32'd0);
        chk("clr_edge_ab", 32'({CHA, CHB}), 32'b10);
        step();
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_ready", 32'(cmd_ready), 32'd1);
        issue(1'b0, 1'b0, 16'd1, 16'd3);
        step();
        step();
        chk("b2b_no_early", 32'({CHA, CHB}), 32'b10);
        step();
        chk("b2b_first_edge", 32'({CHA, CHB}), 32'b11);
        chk("b2b_pos", 32'(pos), 32'd1);
        step();
        chk("b2b_done2", 32'(done), 32'd1);

        // Reset mid-run after three edges (AB 11 -> 01 -> 00 -> 10)
        issue(1'b0, 1'b0, 16'd10, 16'd1);
        step();
        step();
        step();
        chk("prerst_ab", 32'({CHA, CHB}), 32'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ab", 32'({CHA, CHB}), 32'b00);
        chk("midrst_pos", 32'(pos), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (done !== 1'b0 || {CHA, CHB} !== 2'b00) ok = 1'b0;
            step();
        end
        chk("midrst_no_done", 32'(ok), 32'd1);

        // Zero-step command
        issue(1'b0, 1'b1, 16'd0, 16'd5);
        chk("zero_busy", 32'(busy), 32'd1);
        step();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_ab", 32'({CHA, CHB}), 32'b00);
        chk("zero_pos", 32'(pos), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
